clip_video_to_stream: RTL

- Sits directly downstream of the clipper window stage. Consumes its clipped sync/DE timing plus the pixel bus, which arrives aligned with the clipped DE.
- Converts the free-running video timing into a backpressured AXI4-Stream video stream for the VDMA write channel. Frame start is marked on tuser and end of line on tlast.
- Elastic FIFO absorbs sink stalls. Video input cannot stall, so FIFO overflow is detected and reported, never back-pressured.

---
 rtl/clip_video_to_stream.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/clip_video_to_stream.sv
// Clipped video timing + pixels -> AXI4-Stream video (tuser = SOF, tlast = EOL) through an elastic FWFT FIFO.
// Optional build macro CLIP_VIDEO_TO_STREAM_DROP_FRAME_EN: after an overflow, drop the rest of the frame until invsync.
module clip_video_to_stream #(
  parameter int DSIZE   = 24,
  parameter int FIFO_AW = 4
) (
  input  logic               pclk,
  input  logic               prst,
  input  logic               invsync,
  input  logic               inde,
  input  logic [DSIZE-1:0]   indata,
  output logic [DSIZE-1:0]   m_tdata,
  output logic               m_tvalid,
  input  logic               m_tready,
  output logic               m_tuser,
  output logic               m_tlast,
  output logic               overflow,
  input  logic               ovf_clr,
  output logic [FIFO_AW:0]   fifo_level
);

  localparam int LW    = FIFO_AW + 1;
  localparam int WW    = DSIZE + 2;
  localparam int DEPTH = 1 << FIFO_AW;

  // Stream handshake: a beat transfers on a rising pclk where m_tvalid & m_tready;
  // while m_tvalid=1 and m_tready=0 the beat (tdata/tuser/tlast) is held unchanged.

  logic             vsync_q;
  logic             sof_pending_q;
  logic             hold_valid_q;
  logic             hold_user_q;
  logic [DSIZE-1:0] hold_data_q;

  logic [LW-1:0]    wr_ptr_q, rd_ptr_q, wr_ptr_d, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             out_valid_q;
  logic [WW-1:0]    out_word_q;
  logic             ovf_q;

  logic [WW-1:0]    mem [DEPTH];

  logic             vs_rise;
  logic             wr_req;
  logic             wr_allow;
  logic             full;
  logic             pop;
  logic             push;
  logic             ovf_event;
  logic [WW-1:0]    wr_word;
  logic [WW-1:0]    head_word;

  assign vs_rise   = invsync & ~vsync_q;
  assign wr_req    = hold_valid_q;
  // The held pixel ends its line when DE drops now, or when a new frame cuts the line short.
  assign wr_word   = {hold_user_q, ~inde | vs_rise, hold_data_q};
  assign full      = level_q[FIFO_AW];
  assign pop       = out_valid_q & m_tready;
  assign ovf_event = wr_req & full & ~pop;
  assign push      = wr_req & wr_allow & (~full | pop);

  assign rd_ptr_d  = rd_ptr_q + LW'(pop);
  assign wr_ptr_d  = wr_ptr_q + LW'(push);
  assign level_d   = level_q + LW'(push) - LW'(pop);

  // Next head of queue; when the new read pointer meets the old write pointer the head is the word written now.
  assign head_word = (push && (rd_ptr_d == wr_ptr_q)) ? wr_word : mem[rd_ptr_d[FIFO_AW-1:0]];

`ifdef CLIP_VIDEO_TO_STREAM_DROP_FRAME_EN
  logic drop_q;

  always_ff @(posedge pclk) begin
    if (prst) begin
      drop_q <= 1'b0;
    end else if (invsync) begin
      drop_q <= 1'b0;
    end else if (ovf_event) begin
      drop_q <= 1'b1;
    end
  end

  assign wr_allow = ~drop_q;
`else
  assign wr_allow = 1'b1;
`endif

  always_ff @(posedge pclk) begin
    if (push) begin
      mem[wr_ptr_q[FIFO_AW-1:0]] <= wr_word;
    end
  end

  always_ff @(posedge pclk) begin
    if (prst) begin
      vsync_q       <= 1'b0;
      sof_pending_q <= 1'b1;
      hold_valid_q  <= 1'b0;
      hold_user_q   <= 1'b0;
      hold_data_q   <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      level_q       <= '0;
      out_valid_q   <= 1'b0;
      out_word_q    <= '0;
      ovf_q         <= 1'b0;
    end else begin
      vsync_q <= invsync;
      if (inde) begin
        sof_pending_q <= 1'b0;
      end else if (invsync) begin
        sof_pending_q <= 1'b1;
      end
      hold_valid_q <= inde;
      if (inde) begin
        hold_data_q <= indata;
        hold_user_q <= sof_pending_q | invsync;
      end
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      out_valid_q <= (level_d != '0);
      if (level_d != '0) begin
        out_word_q <= head_word;
      end
      if (ovf_clr) begin
        ovf_q <= 1'b0;
      end else if (ovf_event) begin
        ovf_q <= 1'b1;
      end
    end
  end

  assign m_tvalid   = out_valid_q;
  assign m_tuser    = out_word_q[WW-1];
  assign m_tlast    = out_word_q[WW-2];
  assign m_tdata    = out_word_q[DSIZE-1:0];
  assign overflow   = ovf_q;
  assign fifo_level = level_q;

endmodule
